// File: rtl/sipo_deser.sv
// sipo_deser: serial-in/parallel-out deserializer with a one-word output
// holding register and a valid/ready handshake.
// Optional build macro SIPO_DESER_PARITY_EN appends one even-parity bit to
// every frame. The parity bit is checked into perr and never enters q or dout.
module sipo_deser #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr,
    input  logic                       load,
    input  logic                       sin,
    output logic [WIDTH-1:0]           q,
    output logic [$clog2(WIDTH+1)-1:0] bit_cnt,
    output logic [WIDTH-1:0]           dout,
    output logic                       dout_valid,
    input  logic                       dout_ready,
    output logic                       overrun,
    output logic                       perr
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
`ifdef SIPO_DESER_PARITY_EN
    localparam int unsigned FRAME_BITS = WIDTH + 1;
`else
    localparam int unsigned FRAME_BITS = WIDTH;
`endif

    logic [WIDTH-1:0] r_q;
    logic [CNT_W-1:0] r_bit_cnt;
    logic [WIDTH-1:0] r_dout;
    logic             r_dout_valid;
    logic             r_overrun;

    logic             w_sample;
    logic             w_data_bit;
    logic             w_complete;
    logic             w_accept;
    logic [WIDTH-1:0] w_next_q;
    logic [WIDTH-1:0] w_word;

    // Shift path: a sample is taken only when load is high and clr is not.
    always_comb begin
        w_sample = load & ~clr;
        if (MSB_FIRST) begin
            w_next_q = {r_q[WIDTH-2:0], sin};
        end else begin
            w_next_q = {sin, r_q[WIDTH-1:1]};
        end
`ifdef SIPO_DESER_PARITY_EN
        // The trailing parity bit leaves q untouched, so q already holds the word.
        w_data_bit = (r_bit_cnt < CNT_W'(WIDTH));
        w_word     = r_q;
`else
        w_data_bit = 1'b1;
        w_word     = w_next_q;
`endif
        w_complete = w_sample && (r_bit_cnt == CNT_W'(FRAME_BITS - 1));
        // A finished word is taken if the holding register is empty or drains on this edge.
        w_accept   = w_complete && (!r_dout_valid || dout_ready);
    end

    // Shift register, frame bit counter and sticky overrun flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q       <= '0;
            r_bit_cnt <= '0;
            r_overrun <= 1'b0;
        end else if (clr) begin
            r_q       <= '0;
            r_bit_cnt <= '0;
            r_overrun <= 1'b0;
        end else if (load) begin
            if (w_data_bit) begin
                r_q <= w_next_q;
            end
            if (w_complete) begin
                r_bit_cnt <= '0;
            end else begin
                r_bit_cnt <= r_bit_cnt + CNT_W'(1);
            end
            if (w_complete && !w_accept) begin
                r_overrun <= 1'b1;
            end
        end
    end

`ifdef SIPO_DESER_PARITY_EN
    logic r_perr;

    // Output holding register with parity result; perr is cleared whenever the word drains.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_perr       <= 1'b0;
        end else if (w_accept) begin
            r_dout       <= w_word;
            r_dout_valid <= 1'b1;
            r_perr       <= (^r_q) ^ sin;
        end else if (r_dout_valid && dout_ready) begin
            r_dout_valid <= 1'b0;
            r_perr       <= 1'b0;
        end
    end

    assign perr = r_perr;
`else
    // Output holding register loaded on accepted frame completion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
        end else if (w_accept) begin
            r_dout       <= w_word;
            r_dout_valid <= 1'b1;
        end else if (r_dout_valid && dout_ready) begin
            r_dout_valid <= 1'b0;
        end
    end

    assign perr = 1'b0;
`endif

    assign q          = r_q;
    assign bit_cnt    = r_bit_cnt;
    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;
    assign overrun    = r_overrun;

endmodule

// File: tb/tb_sipo_deser.sv
// tb_sipo_deser: directed self-checking bench for sipo_deser (WIDTH=4).
// u_dut is MSB-first and u_lsb is LSB-first. Both instances share clk, rst,
// clr and dout_ready.
module tb_sipo_deser;

    localparam int unsigned W  = 4;
    localparam int unsigned CW = $clog2(W + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          clr;
    logic          load;
    logic          sin;
    logic          dout_ready;
    logic [W-1:0]  q;
    logic [CW-1:0] bit_cnt;
    logic [W-1:0]  dout;
    logic          dout_valid;
    logic          overrun;
    logic          perr;

    logic          load2;
    logic          sin2;
    logic [W-1:0]  q2;
    logic [CW-1:0] bit_cnt2;
    logic [W-1:0]  dout2;
    logic          dout_valid2;
    logic          overrun2;
    logic          perr2;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    sipo_deser #(.WIDTH(W), .MSB_FIRST(1'b1)) u_dut (
        .clk(clk), .rst(rst), .clr(clr), .load(load), .sin(sin),
        .q(q), .bit_cnt(bit_cnt), .dout(dout), .dout_valid(dout_valid),
        .dout_ready(dout_ready), .overrun(overrun), .perr(perr)
    );

    sipo_deser #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst(rst), .clr(clr), .load(load2), .sin(sin2),
        .q(q2), .bit_cnt(bit_cnt2), .dout(dout2), .dout_valid(dout_valid2),
        .dout_ready(dout_ready), .overrun(overrun2), .perr(perr2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One sampled bit on u_dut; returns 1 time unit after the sampling edge.
    task automatic shift_bit(input logic b);
        @(negedge clk);
        load = 1'b1;
        sin  = b;
        @(posedge clk);
        #1;
        load = 1'b0;
        sin  = 1'b0;
    endtask

    task automatic shift_lsb(input logic b);
        @(negedge clk);
        load2 = 1'b1;
        sin2  = b;
        @(posedge clk);
        #1;
        load2 = 1'b0;
        sin2  = 1'b0;
    endtask

    task automatic tick();
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; load = 1'b0; sin = 1'b0; dout_ready = 1'b0;
        load2 = 1'b0; sin2 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_q", 32'(q), 32'h0);
        check("rst_cnt", 32'(bit_cnt), 32'h0);
        check("rst_dout", 32'(dout), 32'h0);
        check("rst_valid", 32'(dout_valid), 32'h0);
        check("rst_ovr", 32'(overrun), 32'h0);
        check("rst_perr", 32'(perr), 32'h0);
        @(negedge clk);
        rst = 1'b0;

`ifdef SIPO_DESER_PARITY_EN
        // Frame 1011 with parity 0: odd number of ones, so perr must be set.
        shift_bit(1'b1); shift_bit(1'b0); shift_bit(1'b1); shift_bit(1'b1);
        check("p_data_cnt", 32'(bit_cnt), 32'h4);
        check("p_data_valid", 32'(dout_valid), 32'h0);
        check("p_data_q", 32'(q), 32'hb);
        shift_bit(1'b0);
        check("p0_dout", 32'(dout), 32'hb);
        check("p0_valid", 32'(dout_valid), 32'h1);
        check("p0_perr", 32'(perr), 32'h1);
        check("p0_q", 32'(q), 32'hb);
        check("p0_cnt", 32'(bit_cnt), 32'h0);
        dout_ready = 1'b1;
        tick();
        dout_ready = 1'b0;
        check("p_drain_valid", 32'(dout_valid), 32'h0);
        check("p_drain_perr", 32'(perr), 32'h0);
        // Same frame with parity 1: even parity holds.
        shift_bit(1'b1); shift_bit(1'b0); shift_bit(1'b1); shift_bit(1'b1);
        shift_bit(1'b1);
        check("p1_dout", 32'(dout), 32'hb);
        check("p1_valid", 32'(dout_valid), 32'h1);
        check("p1_perr", 32'(perr), 32'h0);
        // LSB-first frame 1,0,0,0 + parity 1 -> 0001, no error.
        shift_lsb(1'b1); shift_lsb(1'b0); shift_lsb(1'b0); shift_lsb(1'b0);
        shift_lsb(1'b1);
        check("lsb_p_dout", 32'(dout2), 32'h1);
        check("lsb_p_perr", 32'(perr2), 32'h0);
`else
        // Frame 1011 with the consumer stalled.
        shift_bit(1'b1); shift_bit(1'b0);
        check("f0_mid_q", 32'(q), 32'h2);
        check("f0_mid_cnt", 32'(bit_cnt), 32'h2);
        shift_bit(1'b1); shift_bit(1'b1);
        check("f0_dout", 32'(dout), 32'hb);
        check("f0_valid", 32'(dout_valid), 32'h1);
        check("f0_cnt", 32'(bit_cnt), 32'h0);
        check("f0_q", 32'(q), 32'hb);
        check("f0_perr", 32'(perr), 32'h0);
        tick();
        check("hold_q", 32'(q), 32'hb);
        check("hold_cnt", 32'(bit_cnt), 32'h0);

        // Second frame completes while 1011 is still pending: dropped.
        shift_bit(1'b0); shift_bit(1'b0); shift_bit(1'b0); shift_bit(1'b1);
        check("ovr_dout", 32'(dout), 32'hb);
        check("ovr_flag", 32'(overrun), 32'h1);
        check("ovr_q", 32'(q), 32'h1);
        tick();
        check("ovr_sticky", 32'(overrun), 32'h1);

        // clr with load high: clr wins, pending word survives.
        @(negedge clk);
        clr = 1'b1; load = 1'b1; sin = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0; load = 1'b0; sin = 1'b0;
        check("clr_ovr", 32'(overrun), 32'h0);
        check("clr_cnt", 32'(bit_cnt), 32'h0);
        check("clr_q", 32'(q), 32'h0);
        check("clr_valid", 32'(dout_valid), 32'h1);
        check("clr_dout", 32'(dout), 32'hb);

        // Frame 0110 completes on the same edge 1011 is consumed.
        shift_bit(1'b0); shift_bit(1'b1); shift_bit(1'b1);
        check("stall_dout", 32'(dout), 32'hb);
        dout_ready = 1'b1;
        shift_bit(1'b0);
        check("swap_dout", 32'(dout), 32'h6);
        check("swap_valid", 32'(dout_valid), 32'h1);
        check("swap_ovr", 32'(overrun), 32'h0);
        tick();
        dout_ready = 1'b0;
        check("drain_valid", 32'(dout_valid), 32'h0);
        check("drain_dout", 32'(dout), 32'h6);

        // Asynchronous reset mid-frame, then a clean frame 1100.
        shift_bit(1'b1); shift_bit(1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_q", 32'(q), 32'h0);
        check("arst_cnt", 32'(bit_cnt), 32'h0);
        check("arst_dout", 32'(dout), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        shift_bit(1'b1); shift_bit(1'b1); shift_bit(1'b0); shift_bit(1'b0);
        check("post_rst_dout", 32'(dout), 32'hc);
        check("post_rst_valid", 32'(dout_valid), 32'h1);
        check("post_rst_q", 32'(q), 32'hc);

        // LSB-first: 1,0,0,0 -> first bit ends in q[0].
        shift_lsb(1'b1); shift_lsb(1'b0);
        check("lsb_mid_q", 32'(q2), 32'h4);
        shift_lsb(1'b0); shift_lsb(1'b0);
        check("lsb_dout", 32'(dout2), 32'h1);
        check("lsb_valid", 32'(dout_valid2), 32'h1);
        check("lsb_ovr", 32'(overrun2), 32'h0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sipo_deser.md
SIPO_DESER -- requirements
Module: sipo_deser

Interface
REQ-001 SHALL have parameter WIDTH, default 8, word width in bits (minimum 2).
REQ-002 SHALL have parameter MSB_FIRST, default 1: 1 = first serial bit lands in q[WIDTH-1]; 0 = first bit lands in q[0].
REQ-003 clk  input  1  sole clock, all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 clr  input  1  synchronous clear of the frame in progress and the overrun flag.
REQ-006 load  input  1  shift enable: sin is sampled on this edge when high.
REQ-007 sin  input  1  serial data in.
REQ-008 q  output  WIDTH  live shift-register contents, partial frame.
REQ-009 bit_cnt  output  $clog2(WIDTH+1)  bits received in the current frame.
REQ-010 dout  output  WIDTH  last completed word, held stable while dout_valid=1.
REQ-011 dout_valid  output  1  dout holds an unconsumed word.
REQ-012 dout_ready  input  1  consumer accepts dout when dout_valid=1.
REQ-013 overrun  output  1  sticky: a completed word was dropped.
REQ-014 perr  output  1  parity error flag qualified by dout_valid (see Configuration).

Function
REQ-015 Edge with load=1, MSB_FIRST=1: q <= {q[WIDTH-2:0], sin}; MSB_FIRST=0: q <= {sin, q[WIDTH-1:1]}.
REQ-016 Edge with load=0: q and bit_cnt SHALL hold.
REQ-017 bit_cnt SHALL increment per sampled data bit and wrap to 0 on the edge that completes a frame.
REQ-018 On the completing edge, the full word, including the bit sampled on that edge, SHALL be written to dout with dout_valid=1 visible after that same edge (zero extra latency).
REQ-019 Handshake: dout_valid=1 and dout_ready=1 on an edge = word consumed; dout_valid SHALL clear unless a new word completes on the same edge.
REQ-020 Simultaneous complete + consume: dout SHALL take the new word and dout_valid SHALL stay 1; no overrun.
REQ-021 Complete while dout_valid=1 and dout_ready=0: new word SHALL be dropped, dout unchanged, overrun SHALL set and stay set until clr or rst.
REQ-022 clr=1: q<=0, bit_cnt<=0, overrun<=0; dout/dout_valid unaffected; clr SHALL take priority over load on the same edge.
REQ-023 dout and dout_valid SHALL NOT change while dout_valid=1 and dout_ready=0, except via rst.
REQ-024 q SHALL NOT be cleared on frame completion; the next frame shifts over it.

Reset
REQ-025 rst=1 SHALL immediately force q=0, bit_cnt=0, dout=0, dout_valid=0, overrun=0, perr=0, independent of clk.
REQ-026 Reset mid-frame SHALL discard the partial frame; the first sampled bit after release SHALL be bit 0 of a new frame.

Configuration
REQ-027 Macro SIPO_DESER_PARITY_EN defined: a frame SHALL be WIDTH data bits followed by 1 even-parity bit; bit_cnt counts to WIDTH+1; the parity bit SHALL NOT enter q or dout; perr SHALL be loaded with (XOR of data bits XOR parity bit) alongside dout.
REQ-028 Macro undefined: a frame SHALL be WIDTH bits and perr SHALL be tied to 0; port list identical in both builds.

Verification (WIDTH=4, MSB_FIRST=1, macro undefined unless stated)
REQ-029 rst, then load=1, sin=1,0,1,1 on 4 edges, dout_ready=0 -> after 4th edge dout=1011, dout_valid=1, bit_cnt=0, q=1011.
REQ-030 Hold dout_ready=0, shift 0,0,0,1 -> dout stays 1011, overrun=1; then clr -> overrun=0, bit_cnt=0, dout_valid=1.
REQ-031 dout_ready=1 on the same edge the 4th bit of frame 0110 is sampled with 1011 pending -> dout=0110, dout_valid=1, overrun=0.
REQ-032 MSB_FIRST=0, shift 1,0,0,0 -> dout=0001.
REQ-033 Assert rst asynchronously after 2 bits, release, shift 1,1,0,0 -> dout=1100, no stale bits.
REQ-034 SIPO_DESER_PARITY_EN defined, shift 1,0,1,1 then parity 0 -> dout=1011, perr=1; repeat with parity 1 -> perr=0.
